vec_reduce_acc: RTL
===================

VEC_REDUCE_ACC -- requirements
Module: vec_reduce_acc

Interface
REQ-001 SHALL have parameter LANES, default 8, number of input lanes, power of two, 2..32.
REQ-002 SHALL have parameter DATA_W, default 32, signed two's-complement lane width.
REQ-003 SHALL have parameter ACC_W, default 48, accumulator/result width, at least DATA_W+log2(LANES).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port in_last  input  1  marks the final beat of a frame.
REQ-010 SHALL have port in_mode  input  1  0 = sum, 1 = signed max; meaningful on the first beat of a frame only.
REQ-011 SHALL have port out_valid  output  1  frame result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_data  output  ACC_W  frame result, signed.
REQ-014 SHALL have port out_count  output  16  number of beats in the frame, saturating at 65535.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL drive a global advance enable en = !(out_valid && !out_ready); in_ready SHALL equal en.
REQ-017 SHALL implement a reduction tree of L = log2(LANES) registered levels; each level holds a valid bit, last bit and mode bit that travel with the data; every register advances only when en = 1.
REQ-018 SHALL, per level, combine pairs as a+b in sum mode and as signed max(a,b) in max mode, sign-extending one bit per level (level-k width DATA_W+k).
REQ-019 SHALL latch the mode of a frame's first beat and apply it to every beat of that frame, ignoring in_mode on later beats.
REQ-020 SHALL contain an accumulator stage after level L: on the first beat of a frame it loads the sign-extended tree result; on later beats it adds (sum) or takes signed max (max) into ACC_W bits.
REQ-021 SHALL wrap sum overflow modulo 2^ACC_W with no saturation or flag.
REQ-022 SHALL count accepted beats per frame, saturating at 65535; the counter restarts at 1 on the first beat of the next frame.
REQ-023 SHALL, when the last beat reaches the accumulator, load out_data with the final value, out_count with the beat count, and set out_valid in the same edge; latency from accepting the in_last beat to out_valid = 1 is L+1 cycles (4 for LANES=8) when unstalled.
REQ-024 SHALL hold out_valid, out_data and out_count stable while out_valid=1 and out_ready=0, and stall the whole pipeline (no beat lost or duplicated).
REQ-025 SHALL clear out_valid on the edge where out_valid and out_ready are both 1, unless a new result is loaded in that same edge, in which case out_valid stays 1 with the new values.
REQ-026 SHALL treat a beat with in_last=1 and no prior beats as a one-beat frame (out_count=1).
REQ-027 SHALL support back-to-back frames with no idle cycle between in_last of one frame and the first beat of the next.
REQ-028 SHALL keep out_data and out_count unchanged when out_valid=0 until the next result loads.

Reset
REQ-029 SHALL, while rst=1, force every pipeline valid bit, out_valid, out_data, out_count, the frame-start flag and the beat counter to 0, independent of clk.
REQ-030 SHALL drive in_ready=1 from the first cycle after rst deasserts.
REQ-031 SHALL discard any partial frame or pending result on reset; the first beat after reset starts a new frame.

Verification
REQ-032 SHALL pass: LANES=8, one beat lanes 1..8, in_last=1, mode 0, out_ready=1 -> out_valid 4 cycles later, out_data=36, out_count=1.
REQ-033 SHALL pass: mode 1, 3 beats {-5 x8}, {lanes -1..-8}, {7,0,..,0}, in_mode changed to 0 on beats 2-3 -> out_data=7, out_count=3.
REQ-034 SHALL pass: two frames back-to-back, sum, frame A 2 beats all lanes 1, frame B 1 beat all lanes -1 -> results 16 then -8, consecutive cycles.
REQ-035 SHALL pass: out_ready held 0 for 5 cycles with a result pending and in_valid=1 -> in_ready=0, out_data stable, and each later result correct after release.
REQ-036 SHALL pass: sum of 70000 beats all lanes 0x7FFFFFFF -> out_count=65535, out_data = 70000*8*(2^31-1) mod 2^48.
REQ-037 SHALL pass: rst asserted mid-frame after 2 beats -> outputs 0 immediately, and the next 1-beat frame of lanes 1 yields out_data=8, out_count=1.

Source files
------------

// File: rtl/vec_reduce_acc.sv
// Streaming lane reduction (sum or signed max) with per-frame accumulation.
// Registered input stage, log2(LANES) registered tree levels, then accumulator/output.

module vr_node #(
  parameter int W = 32
) (
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   y
);
  logic [W:0] sa, sb;
  assign sa = {a[W-1], a};
  assign sb = {b[W-1], b};
  assign y  = mode ? (($signed(a) > $signed(b)) ? sa : sb) : (sa + sb);
endmodule

module vec_reduce_acc #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic [15:0]             out_count
);
  localparam int L  = $clog2(LANES);
  localparam int TW = DATA_W + L;

  logic en, accept;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Mode is sampled on a frame's first beat and reused for the rest of it.
  logic in_frame, mode_lat, beat_mode;
  assign beat_mode = in_frame ? mode_lat : in_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame <= 1'b0;
      mode_lat <= 1'b0;
    end else if (accept) begin
      in_frame <= !in_last;
      if (!in_frame) mode_lat <= in_mode;
    end
  end

  logic [L:0] vld_pipe, last_pipe, mode_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      mode_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[L-1:0], accept};
      last_pipe <= {last_pipe[L-1:0], in_last};
      mode_pipe <= {mode_pipe[L-1:0], beat_mode};
    end
  end

  // Level k holds LANES>>k values, each DATA_W+k bits wide.
  for (genvar k = 0; k <= L; k++) begin : lvl
    localparam int N = LANES >> k;
    localparam int W = DATA_W + k;
    logic [N-1:0][W-1:0] q;
    if (k == 0) begin : g_in
      always_ff @(posedge clk) if (en) q <= in_data;
    end else begin : g_red
      logic [N-1:0][W-1:0] y;
      for (genvar j = 0; j < N; j++) begin : node
        vr_node #(.W(W-1)) u_node (
          .mode (mode_pipe[k-1]),
          .a    (lvl[k-1].q[2*j]),
          .b    (lvl[k-1].q[2*j+1]),
          .y    (y[j])
        );
      end
      always_ff @(posedge clk) if (en) q <= y;
    end
  end

  logic [TW-1:0]    t;
  logic [ACC_W-1:0] t_ext, acc, acc_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic             acc_busy;

  assign t     = lvl[L].q[0];
  assign t_ext = ACC_W'($signed(t));

  always_comb begin
    acc_nxt = t_ext;
    cnt_nxt = 16'd1;
    if (acc_busy) begin
      if (mode_pipe[L]) acc_nxt = ($signed(t_ext) > $signed(acc)) ? t_ext : acc;
      else              acc_nxt = acc + t_ext;
      cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end
  end

  // With en high, any held result is being consumed, so out_valid only
  // survives the edge if a new result lands on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_busy  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (en) begin
      out_valid <= vld_pipe[L] && last_pipe[L];
      if (vld_pipe[L]) begin
        acc      <= acc_nxt;
        cnt      <= cnt_nxt;
        acc_busy <= !last_pipe[L];
        if (last_pipe[L]) begin
          out_data  <= acc_nxt;
          out_count <= cnt_nxt;
        end
      end
    end
  end
endmodule
